led_pio_out: RTL and testbench



---
 rtl/led_pio_pkg.sv | 11 +
 rtl/led_blink_timer.sv | 65 ++++++
 rtl/led_pio_out.sv | 96 +++++++++
 tb/tb_led_pio_out.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pio_pkg.sv
// rtl/led_pio_pkg.sv - register map constants for the LED output port
package led_pio_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_BLINK  = 2'd1;
  localparam logic [1:0] ADDR_PERIOD = 2'd2;
  localparam logic [1:0] ADDR_TOGGLE = 2'd3;

  localparam int PHASE_BIT = 31;

endpackage

// File: rtl/led_blink_timer.sv
// rtl/led_blink_timer.sv - prescaler plus half-period counter producing the blink phase
module led_blink_timer
  import led_pio_pkg::*;
#(
  parameter int CLK_DIV = 1000,
  parameter int PER_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PER_W-1:0] period,
  input  logic             restart,
  output logic             phase,
  output logic [PER_W-1:0] tick_cnt
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             tick;

  // With CLK_DIV=1 the counter is pinned at 0 and tick stays high.
  assign tick = (div_q == DIV_LAST);

  always_comb begin
    div_d   = div_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (restart) begin
      div_d = '0;
      cnt_d = '0;
    end else begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (period == '0) begin
        cnt_d   = '0;
        phase_d = 1'b0;
      end else if (tick) begin
        if (cnt_q == period - 1'b1) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase    = phase_q;
  assign tick_cnt = cnt_q;

endmodule

// File: rtl/led_pio_out.sv
// rtl/led_pio_out.sv - Avalon-MM LED output port with hardware blink
module led_pio_out
  import led_pio_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int CLK_DIV = 1000,
  parameter int PER_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             wr_en;
  logic             restart;
  logic             phase;
  logic [PER_W-1:0] tick_cnt;
  logic             unused_wdata;

  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] blink_q, blink_d;
  logic [PER_W-1:0] period_q, period_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [WIDTH-1:0] out_q, out_d;

  assign wr_en        = chipselect & ~write_n;
  assign restart      = wr_en && (address == ADDR_PERIOD);
  assign unused_wdata = ^writedata[31:PER_W];

  led_blink_timer #(
    .CLK_DIV (CLK_DIV),
    .PER_W   (PER_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .period   (period_q),
    .restart  (restart),
    .phase    (phase),
    .tick_cnt (tick_cnt)
  );

  always_comb begin
    data_d   = data_q;
    blink_d  = blink_q;
    period_d = period_q;
    if (wr_en) begin
      case (address)
        ADDR_DATA:   data_d   = writedata[WIDTH-1:0];
        ADDR_BLINK:  blink_d  = writedata[WIDTH-1:0];
        ADDR_PERIOD: period_d = writedata[PER_W-1:0];
        default:     data_d   = data_q ^ writedata[WIDTH-1:0];
      endcase
    end
  end

  // Read mux sees pre-write contents, so a same-edge write is read-old.
  always_comb begin
    rdata_d = '0;
    case (address)
      ADDR_DATA:   rdata_d[WIDTH-1:0] = data_q;
      ADDR_BLINK:  rdata_d[WIDTH-1:0] = blink_q;
      ADDR_PERIOD: rdata_d[PER_W-1:0] = period_q;
      default: begin
        rdata_d[PER_W-1:0] = tick_cnt;
        rdata_d[PHASE_BIT] = phase;
      end
    endcase
  end

  assign out_d = data_q & (~blink_q | {WIDTH{phase}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= '0;
      blink_q  <= '0;
      period_q <= '0;
      rdata_q  <= '0;
      out_q    <= '0;
    end else begin
      data_q   <= data_d;
      blink_q  <= blink_d;
      period_q <= period_d;
      rdata_q  <= rdata_d;
      out_q    <= out_d;
    end
  end

  assign readdata = rdata_q;
  assign out_port = out_q;

endmodule

// File: tb/tb_led_pio_out.sv
// tb/tb_led_pio_out.sv - self-checking bench for led_pio_out
module tb_led_pio_out;

  localparam int CLK_DIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [1:0]  out_port;

  int checks = 0;
  int errors = 0;

  logic [1:0]  m_data, m_blink, m_out;
  logic [15:0] m_per;
  logic        m_phase;
  logic [31:0] m_rd;
  int unsigned m_k;

  led_pio_out #(
    .WIDTH   (2),
    .CLK_DIV (CLK_DIV),
    .PER_W   (16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // m_k counts edges since the counters were last cleared; ticks = m_k / CLK_DIV.
  task automatic model_update();
    if (reset) begin
      m_data = '0; m_blink = '0; m_per = '0; m_phase = 1'b0;
      m_k = 0; m_rd = '0; m_out = '0;
    end else begin
      m_rd = '0;
      case (address)
        2'd0: m_rd[1:0] = m_data;
        2'd1: m_rd[1:0] = m_blink;
        2'd2: m_rd[15:0] = m_per;
        default: begin
          m_rd[15:0] = (m_per == 0) ? 16'd0 : 16'((m_k / CLK_DIV) % m_per);
          m_rd[31]   = m_phase;
        end
      endcase
      m_out = m_data & (~m_blink | {2{m_phase}});
      if (chipselect && !write_n && address == 2'd2) begin
        m_k = 0;
      end else begin
        m_k++;
        if (m_per == 0) m_phase = 1'b0;
        else if (m_k % (CLK_DIV * m_per) == 0) m_phase = ~m_phase;
      end
      if (chipselect && !write_n) begin
        case (address)
          2'd0: m_data = writedata[1:0];
          2'd1: m_blink = writedata[1:0];
          2'd2: m_per = writedata[15:0];
          default: m_data = m_data ^ writedata[1:0];
        endcase
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("model out_port", {30'd0, out_port}, {30'd0, m_out});
    check("model readdata", readdata, m_rd);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] v);
    address = a;
    step();
    v = readdata;
  endtask

  task automatic measure_gap(output int gap, output bit b1_ok);
    logic prev;
    int   n;
    b1_ok = 1'b1;
    gap   = -1;
    prev  = out_port[0];
    n     = 0;
    while (out_port[0] == prev && n < 40) begin
      step(); n++;
      if (out_port[1] !== 1'b1) b1_ok = 1'b0;
    end
    prev = out_port[0];
    n    = 0;
    while (out_port[0] == prev && n < 40) begin
      step(); n++;
      if (out_port[1] !== 1'b1) b1_ok = 1'b0;
    end
    if (out_port[0] != prev) gap = n;
  endtask

  initial begin
    logic [31:0] v;
    int          gap;
    bit          b1_ok;
    int          n;

    idle(3);
    check("reset out_port", {30'd0, out_port}, 32'd0);
    check("reset readdata", readdata, 32'd0);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), v);
      check("reset read reg", v, 32'd0);
    end

    wr(2'd0, 32'h3);
    check("out_port latency old", {30'd0, out_port}, 32'd0);
    step();
    check("out_port after N+1", {30'd0, out_port}, 32'd3);
    rd(2'd0, v);
    check("read DATA", v, 32'h3);

    wr(2'd1, 32'h1);
    wr(2'd2, 32'h2);
    measure_gap(gap, b1_ok);
    check("blink gap period2", 32'(gap), 32'd8);
    check("out_port[1] steady", {31'd0, b1_ok}, 32'd1);

    wr(2'd0, 32'h2);
    wr(2'd3, 32'h1);
    rd(2'd0, v);
    check("toggle 01", v, 32'h3);
    wr(2'd3, 32'h3);
    rd(2'd0, v);
    check("toggle 11", v, 32'h0);

    wr(2'd0, 32'h3);
    wr(2'd2, 32'd5);
    idle(13);
    wr(2'd2, 32'd1);
    rd(2'd3, v);
    check("tick_cnt after period write", v & 32'hFFFF, 32'd0);
    measure_gap(gap, b1_ok);
    check("blink gap period1", 32'(gap), 32'd4);

    wr(2'd2, 32'd0);
    idle(2);
    check("period0 out_port", {30'd0, out_port}, 32'd2);
    rd(2'd3, v);
    check("period0 status", v, 32'd0);

    wr(2'd2, 32'd1);
    n = 0;
    while (out_port !== 2'b11 && n < 20) begin step(); n++; end
    check("pre-reset out_port", {30'd0, out_port}, 32'd3);
    #2 reset = 1'b1;
    #1;
    check("async reset out_port", {30'd0, out_port}, 32'd0);
    check("async reset readdata", readdata, 32'd0);
    step();
    reset = 1'b0;
    rd(2'd0, v);
    check("DATA after reset", v, 32'd0);

    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, v);
    check("DATA high bits", v, 32'h3);
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, v);
    check("PERIOD high bits", v, 32'h0000_FFFF);

    chipselect = 1'b0; write_n = 1'b0; address = 2'd0; writedata = 32'h0;
    step();
    write_n = 1'b1;
    rd(2'd0, v);
    check("write without chipselect", v, 32'h3);

    wr(2'd1, 32'h1);
    wr(2'd2, 32'd1);
    for (int g = 0; g < 8; g++) begin
      wr(2'd3, 32'h1);
      idle(g);
      wr(2'd2, 32'((g % 3) + 1));
      address = 2'd3;
      idle(g + 1);
    end
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
